// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory read/write port among LSU consumers
module mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
    output logic                                 mem_read_valid,
    output logic [ADDR_BITS-1:0]                 mem_read_address,
    input  logic                                 mem_read_ready,
    input  logic [DATA_BITS-1:0]                 mem_read_data,
    output logic                                 mem_write_valid,
    output logic [ADDR_BITS-1:0]                 mem_write_address,
    output logic [DATA_BITS-1:0]                 mem_write_data,
    input  logic                                 mem_write_ready
);
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAYING,
        WRITE_RELAYING
    } state_t;

    state_t                                  state_q, state_d;
    logic [CW-1:0]                           cur_q, cur_d;
    logic [CW-1:0]                           last_q, last_d;
    logic                                    mem_rd_valid_q, mem_rd_valid_d;
    logic [ADDR_BITS-1:0]                    mem_rd_addr_q, mem_rd_addr_d;
    logic                                    mem_wr_valid_q, mem_wr_valid_d;
    logic [ADDR_BITS-1:0]                    mem_wr_addr_q, mem_wr_addr_d;
    logic [DATA_BITS-1:0]                    mem_wr_data_q, mem_wr_data_d;
    logic [NUM_CONSUMERS-1:0]                rd_ready_q, rd_ready_d;
    logic [NUM_CONSUMERS-1:0]                wr_ready_q, wr_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;

    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] rd_addr_v;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] wr_addr_v;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] wr_data_v;

    logic                                    grant_found;
    logic                                    grant_read;
    logic [CW-1:0]                           grant_idx;
    logic [CW-1:0]                           cand;

    assign rd_addr_v = consumer_read_address;
    assign wr_addr_v = consumer_write_address;
    assign wr_data_v = consumer_write_data;

    // Search begins one past the last served consumer so every requester is reached within N grants.
    always_comb begin
        grant_found = 1'b0;
        grant_read  = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = 1; off <= NUM_CONSUMERS; off++) begin
            cand = CW'((int'(last_q) + off) % NUM_CONSUMERS);
            if (!grant_found && (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
                grant_found = 1'b1;
                grant_idx   = cand;
                grant_read  = consumer_read_valid[cand];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        last_d         = last_q;
        mem_rd_valid_d = mem_rd_valid_q;
        mem_rd_addr_d  = mem_rd_addr_q;
        mem_wr_valid_d = mem_wr_valid_q;
        mem_wr_addr_d  = mem_wr_addr_q;
        mem_wr_data_d  = mem_wr_data_q;
        rd_ready_d     = rd_ready_q;
        wr_ready_d     = wr_ready_q;
        rd_data_d      = rd_data_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    cur_d = grant_idx;
                    if (grant_read) begin
                        mem_rd_valid_d = 1'b1;
                        mem_rd_addr_d  = rd_addr_v[grant_idx];
                        state_d        = READ_WAITING;
                    end else begin
                        mem_wr_valid_d = 1'b1;
                        mem_wr_addr_d  = wr_addr_v[grant_idx];
                        mem_wr_data_d  = wr_data_v[grant_idx];
                        state_d        = WRITE_WAITING;
                    end
                end
            end
            READ_WAITING: begin
                if (mem_read_ready) begin
                    mem_rd_valid_d    = 1'b0;
                    rd_data_d[cur_q]  = mem_read_data;
                    rd_ready_d[cur_q] = 1'b1;
                    state_d           = READ_RELAYING;
                end
            end
            WRITE_WAITING: begin
                if (mem_write_ready) begin
                    mem_wr_valid_d    = 1'b0;
                    wr_ready_d[cur_q] = 1'b1;
                    state_d           = WRITE_RELAYING;
                end
            end
            // Ready stays up until the consumer withdraws its request.
            READ_RELAYING: begin
                if (!consumer_read_valid[cur_q]) begin
                    rd_ready_d[cur_q] = 1'b0;
                    last_d            = cur_q;
                    state_d           = IDLE;
                end
            end
            WRITE_RELAYING: begin
                if (!consumer_write_valid[cur_q]) begin
                    wr_ready_d[cur_q] = 1'b0;
                    last_d            = cur_q;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cur_q          <= '0;
            last_q         <= CW'(NUM_CONSUMERS - 1);
            mem_rd_valid_q <= 1'b0;
            mem_rd_addr_q  <= '0;
            mem_wr_valid_q <= 1'b0;
            mem_wr_addr_q  <= '0;
            mem_wr_data_q  <= '0;
            rd_ready_q     <= '0;
            wr_ready_q     <= '0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            last_q         <= last_d;
            mem_rd_valid_q <= mem_rd_valid_d;
            mem_rd_addr_q  <= mem_rd_addr_d;
            mem_wr_valid_q <= mem_wr_valid_d;
            mem_wr_addr_q  <= mem_wr_addr_d;
            mem_wr_data_q  <= mem_wr_data_d;
            rd_ready_q     <= rd_ready_d;
            wr_ready_q     <= wr_ready_d;
            rd_data_q      <= rd_data_d;
        end
    end

    assign consumer_read_ready  = rd_ready_q;
    assign consumer_write_ready = wr_ready_q;
    assign consumer_read_data   = rd_data_q;
    assign mem_read_valid       = mem_rd_valid_q;
    assign mem_read_address     = mem_rd_addr_q;
    assign mem_write_valid      = mem_wr_valid_q;
    assign mem_write_address    = mem_wr_addr_q;
    assign mem_write_data       = mem_wr_data_q;

endmodule
